// File: rtl/arp_resolver.sv
// rtl/arp_resolver.sv - ARP resolver with local IP->MAC cache, trigger/wait/query retry FSM
module arp_resolver #(
  parameter int CACHE_DEPTH = 4,
  parameter int WAIT_CYCLES = 200000,
  parameter int RETRY_MAX   = 3
) (
  input  logic        logic_clk,
  input  logic        logic_rst,
  input  logic [31:0] req_ip_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  output logic [47:0] res_mac_out,
  output logic        res_err_out,
  output logic        res_valid_out,
  input  logic        res_ready_in,
  input  logic        cache_flush_in,
  output logic        trig_arp_qvalid_out,
  output logic [31:0] trig_arp_ip_out,
  input  logic        trig_arp_qready_in,
  output logic [31:0] arp_query_ip_out,
  output logic        arp_query_valid_out,
  input  logic        arp_query_ready_in,
  input  logic [47:0] arp_response_mac_in,
  input  logic        arp_response_valid_in,
  output logic        arp_response_ready_out,
  input  logic        arp_response_err_in
);
  localparam int PW = $clog2(CACHE_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_TRIG, S_WAIT, S_QUERY, S_RESP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ip_q, ip_d;
  logic [47:0] mac_q, mac_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic [7:0]  attempt_q, attempt_d;
  logic [31:0] wait_q, wait_d;

  logic [CACHE_DEPTH-1:0] valid_q;
  logic [31:0]            tag_q  [CACHE_DEPTH];
  logic [47:0]            data_q [CACHE_DEPTH];
  logic [PW-1:0]          ptr_q;

  logic          hit;
  logic [47:0]   hit_mac;
  logic          wr_en;
  logic [PW-1:0] wr_idx;

  // Parallel compare of the latched IP against every valid entry
  always_comb begin
    hit     = 1'b0;
    hit_mac = '0;
    for (int i = 0; i < CACHE_DEPTH; i++) begin
      if (valid_q[i] && tag_q[i] == ip_q) begin
        hit     = 1'b1;
        hit_mac = hit_mac | data_q[i];
      end
    end
  end

  // A flush in the write cycle empties the cache first, so the new entry lands at index 0
  assign wr_idx = cache_flush_in ? '0 : ptr_q;

  // Next-state and datapath decode for the resolution FSM
  always_comb begin
    state_d   = state_q;
    ip_d      = ip_q;
    mac_d     = mac_q;
    err_d     = err_q;
    attempt_d = attempt_q;
    wait_d    = wait_q;
    wr_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_in && ready_q) begin
          ip_d      = req_ip_in;
          attempt_d = 8'd1;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          mac_d   = hit_mac;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        if (trig_arp_qready_in) begin
          wait_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 32'(WAIT_CYCLES - 1)) begin
          state_d = S_QUERY;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_QUERY: begin
        if (arp_query_ready_in) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (arp_response_valid_in) begin
          if (!arp_response_err_in) begin
            // Never duplicate an IP that survives in the cache
            wr_en   = !(hit && !cache_flush_in);
            mac_d   = arp_response_mac_in;
            err_d   = 1'b0;
            state_d = S_DONE;
          end else if (attempt_q < 8'(RETRY_MAX)) begin
            attempt_d = attempt_q + 8'd1;
            state_d   = S_TRIG;
          end else begin
            mac_d   = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (res_ready_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // FSM and result registers
  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state_q   <= S_IDLE;
      ip_q      <= '0;
      mac_q     <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      attempt_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      ip_q      <= ip_d;
      mac_q     <= mac_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      attempt_q <= attempt_d;
      wait_q    <= wait_d;
    end
  end

  // Cache storage: flush clears valid bits, a same-cycle write then re-sets its own entry
  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      if (cache_flush_in) begin
        valid_q <= '0;
        ptr_q   <= '0;
      end
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
        tag_q[wr_idx]   <= ip_q;
        data_q[wr_idx]  <= arp_response_mac_in;
        ptr_q           <= wr_idx + PW'(1);
      end
    end
  end

  assign req_ready_out          = ready_q;
  assign res_valid_out          = (state_q == S_DONE);
  assign res_mac_out            = mac_q;
  assign res_err_out            = err_q;
  assign trig_arp_qvalid_out    = (state_q == S_TRIG);
  assign trig_arp_ip_out        = ip_q;
  assign arp_query_valid_out    = (state_q == S_QUERY);
  assign arp_query_ip_out       = ip_q;
  assign arp_response_ready_out = (state_q == S_RESP);
endmodule

// File: tb/tb_arp_resolver.sv
// tb/tb_arp_resolver.sv - scoreboard bench for arp_resolver with net_top responder model
module tb_arp_resolver;
  localparam int DEPTH = 4;
  localparam int W     = 20;
  localparam int RMAX  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_ip_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [47:0] res_mac_out;
  logic        res_err_out;
  logic        res_valid_out;
  logic        res_ready_in;
  logic        cache_flush_in;
  logic        trig_arp_qvalid_out;
  logic [31:0] trig_arp_ip_out;
  logic        trig_arp_qready_in;
  logic [31:0] arp_query_ip_out;
  logic        arp_query_valid_out;
  logic        arp_query_ready_in;
  logic [47:0] arp_response_mac_in;
  logic        arp_response_valid_in;
  logic        arp_response_ready_out;
  logic        arp_response_err_in;

  arp_resolver #(.CACHE_DEPTH(DEPTH), .WAIT_CYCLES(W), .RETRY_MAX(RMAX)) dut (
    .logic_clk(clk), .logic_rst(rst),
    .req_ip_in(req_ip_in), .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .res_mac_out(res_mac_out), .res_err_out(res_err_out), .res_valid_out(res_valid_out),
    .res_ready_in(res_ready_in), .cache_flush_in(cache_flush_in),
    .trig_arp_qvalid_out(trig_arp_qvalid_out), .trig_arp_ip_out(trig_arp_ip_out),
    .trig_arp_qready_in(trig_arp_qready_in),
    .arp_query_ip_out(arp_query_ip_out), .arp_query_valid_out(arp_query_valid_out),
    .arp_query_ready_in(arp_query_ready_in),
    .arp_response_mac_in(arp_response_mac_in), .arp_response_valid_in(arp_response_valid_in),
    .arp_response_ready_out(arp_response_ready_out), .arp_response_err_in(arp_response_err_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [47:0] mac;
    int          ntrig;
    bit          hit;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          results = 0;
  logic [47:0] net_mac  [logic [31:0]];
  int          net_fail [logic [31:0]];
  logic [31:0] mc_ip[$];
  logic [47:0] mc_mac[$];
  logic [31:0] cur_ip = '0;
  int          accept_cyc = 0;
  int          trig_cnt = 0, query_cnt = 0;
  int          first_trig_cyc = -1, first_query_cyc = -1;
  bit          directed = 1'b1;
  bit          rand_ready = 1'b0;
  bit          flush_on_write = 1'b0;
  bit          flush_req = 1'b0;
  int          res_stall = 0, trig_stall = 0;
  bit          pending = 1'b0;
  bit          prev_valid = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int mfind(logic [31:0] ip);
    foreach (mc_ip[i]) if (mc_ip[i] == ip) return i;
    return -1;
  endfunction

  function automatic void net_set(logic [31:0] ip, int fail, logic [47:0] mac);
    net_mac[ip]  = mac;
    net_fail[ip] = fail;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic issue(logic [31:0] ip);
    int n;
    cur_ip = ip;
    trig_cnt = 0;
    query_cnt = 0;
    first_trig_cyc = -1;
    first_query_cyc = -1;
    @(negedge clk);
    req_ip_in = ip;
    req_valid_in = 1'b1;
    n = 0;
    while (!req_ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_out) check("accept_timeout", 0, 1);
    accept_cyc = cyc;
    @(negedge clk);
    req_valid_in = 1'b0;
  endtask

  task automatic do_req(logic [31:0] ip);
    exp_t e;
    int   target, n, f;
    e.hit = (mfind(ip) >= 0);
    if (e.hit) begin
      e.mac = mc_mac[mfind(ip)];
      e.err = 1'b0;
      e.ntrig = 0;
    end else begin
      f = net_fail[ip];
      if (f >= RMAX) begin
        e.err = 1'b1;
        e.mac = '0;
        e.ntrig = RMAX;
      end else begin
        e.err = 1'b0;
        e.mac = net_mac[ip];
        e.ntrig = f + 1;
        if (flush_on_write) begin
          mc_ip.delete();
          mc_mac.delete();
        end
        mc_ip.push_back(ip);
        mc_mac.push_back(e.mac);
        if (mc_ip.size() > DEPTH) begin
          void'(mc_ip.pop_front());
          void'(mc_mac.pop_front());
        end
      end
    end
    exp_q.push_back(e);
    target = results + 1;
    issue(ip);
    n = 0;
    while (results < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (results < target) check("result_timeout", 0, 1);
    flush_on_write = 1'b0;
  endtask

  task automatic do_flush();
    flush_req = 1'b1;
    repeat (2) @(negedge clk);
    mc_ip.delete();
    mc_mac.delete();
  endtask

  // net_top model: trigger/query handshakes and table responses
  initial forever begin
    @(negedge clk);
    if (rst) begin
      trig_arp_qready_in = 1'b0;
      arp_query_ready_in = 1'b0;
      arp_response_valid_in = 1'b0;
      arp_response_err_in = 1'b0;
      arp_response_mac_in = '0;
      cache_flush_in = 1'b0;
      pending = 1'b0;
      continue;
    end
    cache_flush_in = 1'b0;
    if (flush_req) begin
      cache_flush_in = 1'b1;
      flush_req = 1'b0;
    end
    if (pending) begin
      arp_response_valid_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (arp_response_valid_in && arp_response_ready_out) begin
        if (!arp_response_err_in && flush_on_write) cache_flush_in = 1'b1;
        pending = 1'b0;
      end
    end else begin
      arp_response_valid_in = 1'b0;
    end
    if (trig_arp_qvalid_out) begin
      if (first_trig_cyc < 0) begin
        first_trig_cyc = cyc;
        if (directed) check("trig_latency", cyc, accept_cyc + 2);
      end
      if (trig_stall > 0) begin
        trig_arp_qready_in = 1'b0;
        trig_stall--;
        check("trig_stall_ip", trig_arp_ip_out, cur_ip);
        check("trig_stall_req_ready", req_ready_out, 0);
      end else begin
        trig_arp_qready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (trig_arp_qready_in) begin
        trig_cnt++;
        check("trig_ip", trig_arp_ip_out, cur_ip);
      end
    end else begin
      trig_arp_qready_in = 1'($urandom_range(0, 1));
    end
    if (arp_query_valid_out) begin
      if (first_query_cyc < 0) begin
        first_query_cyc = cyc;
        if (directed) check("query_latency", cyc, accept_cyc + 3 + W);
      end
      arp_query_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (arp_query_ready_in) begin
        query_cnt++;
        check("query_ip", arp_query_ip_out, cur_ip);
        pending = 1'b1;
        arp_response_err_in = (query_cnt <= net_fail[cur_ip]);
        arp_response_mac_in = arp_response_err_in ? {16'($urandom), $urandom} : net_mac[cur_ip];
      end
    end else begin
      arp_query_ready_in = 1'($urandom_range(0, 1));
    end
  end

  // Result monitor: pops the scoreboard on every result handshake
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      res_ready_in = 1'b0;
      prev_valid = 1'b0;
      continue;
    end
    if (res_valid_out) begin
      if (exp_q.size() == 0) begin
        if (!prev_valid) check("unexpected_result", 1, 0);
        res_ready_in = 1'b1;
      end else begin
        e = exp_q[0];
        if (!prev_valid && e.hit) check("hit_latency", cyc, accept_cyc + 2);
        if (res_stall > 0) begin
          res_ready_in = 1'b0;
          res_stall--;
          check("stall_mac", res_mac_out, e.mac);
          check("stall_err", res_err_out, e.err);
          check("stall_req_ready", req_ready_out, 0);
        end else begin
          res_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (res_ready_in) begin
          void'(exp_q.pop_front());
          check("res_mac", res_mac_out, e.mac);
          check("res_err", res_err_out, e.err);
          check("trig_count", trig_cnt, e.ntrig);
          check("query_count", query_cnt, e.ntrig);
          results++;
        end
      end
    end else begin
      res_ready_in = 1'($urandom_range(0, 1));
    end
    prev_valid = res_valid_out;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pool [8];
    rst = 1'b1;
    req_ip_in = '0;
    req_valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready_out, 0);
    check("rst_res_valid", res_valid_out, 0);
    check("rst_res_err", res_err_out, 0);
    check("rst_res_mac", res_mac_out, 0);
    check("rst_trig_valid", trig_arp_qvalid_out, 0);
    check("rst_trig_ip", trig_arp_ip_out, 0);
    check("rst_query_valid", arp_query_valid_out, 0);
    check("rst_resp_ready", arp_response_ready_out, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", req_ready_out, 1);

    net_set(32'hC0A8_0001, 0, 48'h0011_2233_4455);
    do_req(32'hC0A8_0001);
    do_req(32'hC0A8_0001);

    net_set(32'hC0A8_0002, 3, 48'h0A0B_0C0D_0E0F);
    do_req(32'hC0A8_0002);
    do_req(32'hC0A8_0002);

    do_flush();
    for (int i = 0; i < 5; i++) net_set(32'h0A00_0010 + i, i % 2, {16'hBEEF, 32'h1000 + i});
    for (int i = 0; i < 5; i++) do_req(32'h0A00_0010 + i);
    do_req(32'h0A00_0011);
    do_req(32'h0A00_0010);

    directed = 1'b0;
    trig_stall = 5;
    res_stall = 10;
    net_set(32'h0A00_0020, 0, 48'hCAFE_0000_0020);
    do_req(32'h0A00_0020);
    directed = 1'b1;

    do_flush();
    net_set(32'h0A00_0030, 0, 48'h0000_0000_0030);
    net_set(32'h0A00_0031, 0, 48'h0000_0000_0031);
    do_req(32'h0A00_0030);
    do_req(32'h0A00_0031);
    do_flush();
    do_req(32'h0A00_0030);
    for (int i = 2; i < 7; i++) net_set(32'h0A00_0030 + i, 0, {16'h00AA, 32'h30 + i});
    flush_on_write = 1'b1;
    do_req(32'h0A00_0032);
    do_req(32'h0A00_0032);
    do_req(32'h0A00_0030);
    for (int i = 3; i < 7; i++) do_req(32'h0A00_0030 + i);
    do_req(32'h0A00_0033);
    do_req(32'h0A00_0032);

    net_set(32'h0A00_0040, 0, 48'h0000_0000_0040);
    issue(32'h0A00_0040);
    repeat (W / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mc_ip.delete();
    mc_mac.delete();
    repeat (30) @(negedge clk);
    check("rst_drop_no_result", res_valid_out, 0);
    do_req(32'h0A00_0036);

    rand_ready = 1'b1;
    directed = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pool[i] = 32'h0B00_0100 + 32'(i);
      net_set(pool[i], ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
              {16'($urandom), $urandom});
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) do_flush();
      flush_on_write = ($urandom_range(0, 5) == 0);
      do_req(pool[$urandom_range(0, 7)]);
    end
    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
